// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: next-PC source codes, bubble encoding and fetch FSM states.
package pipe_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pipeif_npc.sv
// Next-PC selector: sequential pc+4 or one of decode's branch/jr/jump targets.
module pipeif_npc
  import pipe_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic [1:0]  pcsource,
  output logic [31:0] npc
);

  always_comb begin
    npc = pc + 32'd4;
    unique case (pcsource)
      PCSRC_SEQ: npc = pc + 32'd4;
      PCSRC_BR:  npc = bpc;
      PCSRC_JR:  npc = rpc;
      PCSRC_J:   npc = jpc;
      default:   npc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/pipeif_fetch.sv
// Fetch stage with PC register, ready-based imem handshake and IF/ID register.
// Optional bubble counter output enabled by defining IF_PERF_CNT_EN.
module pipeif_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] if_bubble_cnt,
`endif
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  input  logic [1:0]  pcsource,
  input  logic        wpcir,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] dinst,
  output logic        dflush
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_dpc4;
  logic [31:0]  r_dinst;
  logic         r_dflush;
  logic [31:0]  r_redir_pc;
  logic [31:0]  r_hold_inst;

  logic [31:0]  w_npc;
  logic [31:0]  w_pc4;
  logic [31:0]  w_cur_inst;
  logic         w_avail;
  logic         w_redirect;
  logic         w_bubble;

  pipeif_npc u_npc (
    .pc       (r_pc),
    .bpc      (bpc),
    .rpc      (rpc),
    .jpc      (jpc),
    .pcsource (pcsource),
    .npc      (w_npc)
  );

  assign w_pc4      = r_pc + 32'd4;
  assign w_avail    = ((r_state == FETCH) && imem_ready) || (r_state == HOLD);
  assign w_cur_inst = (r_state == HOLD) ? r_hold_inst : imem_rdata;
  assign w_redirect = (pcsource != PCSRC_SEQ);
  assign w_bubble   = !w_avail && wpcir;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_dpc4      <= 32'd0;
      r_dinst     <= INST_NOP;
      r_dflush    <= 1'b0;
      r_redir_pc  <= 32'd0;
      r_hold_inst <= INST_NOP;
    end else if (w_avail && wpcir) begin
      r_dinst  <= w_cur_inst;
      r_dpc4   <= w_pc4;
      r_dflush <= flush;
      r_pc     <= w_npc;
      r_state  <= FETCH;
    end else if (w_avail) begin
      // Decode stalled with a fresh response: park it so the bus can go idle.
      if (r_state == FETCH) begin
        r_hold_inst <= imem_rdata;
        r_state     <= HOLD;
      end
    end else begin
      if (wpcir) begin
        r_dinst  <= INST_NOP;
        r_dflush <= 1'b0;
        if (w_redirect) begin
          r_redir_pc <= w_npc;
          if (r_state == FETCH) begin
            r_state <= DROP;
          end
        end
      end
      // Stale response retires the DROP; a redirect arriving this same cycle wins.
      if ((r_state == DROP) && imem_ready) begin
        r_pc    <= (wpcir && w_redirect) ? w_npc : r_redir_pc;
        r_state <= FETCH;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bubble_cnt <= 32'd0;
    end else if (w_bubble) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign if_bubble_cnt = r_bubble_cnt;
`else
  logic w_unused_bubble;
  assign w_unused_bubble = w_bubble;
`endif

  assign imem_req  = (r_state != HOLD);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign dpc4      = r_dpc4;
  assign dinst     = r_dinst;
  assign dflush    = r_dflush;

endmodule

// File: doc/pipeif_fetch.md
Name: pipeif_fetch

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipeline. Sits directly upstream of the decode stage and owns the PC register. Selects next PC from decode's pcsource/bpc/jpc/rpc and fetches over a ready-based instruction-memory handshake. Presents dinst/dpc4/dflush to decode, honouring decode's wpcir stall and inserting bubbles when memory is slow.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clock  in  1  stage clock, rising edge.
reset  in  1  synchronous, active-high reset.
bpc  in  32  branch target from decode.
jpc  in  32  jump target from decode.
rpc  in  32  jr target from decode (forwarded rs value).
pcsource  in  2  00 pc+4, 01 bpc, 10 rpc, 11 jpc.
wpcir  in  1  1 = decode accepts a new instruction this cycle; 0 = load-use stall.
flush  in  1  decode request to nullify the instruction entering ID.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address, equal to pc.
imem_rdata  in  32  instruction; valid only when imem_ready=1.
imem_ready  in  1  fetch completes this cycle.
pc  out  32  current fetch PC.
dpc4  out  32  IF/ID pc+4.
dinst  out  32  IF/ID instruction; 32'h0 = bubble.
dflush  out  1  IF/ID copy of flush.

Behaviour:
- Reset: pc=RESET_PC, dpc4=0, dinst=0, dflush=0, redir_pc=0, hold_inst=0, state=FETCH.
- imem_req=1 in FETCH and DROP, 0 in HOLD. imem_addr=pc. It stays stable while req=1 and ready=0.
- npc: pcsource 00 -> pc+4 (mod 2^32), 01 -> bpc, 10 -> rpc, 11 -> jpc. Ignore pcsource when wpcir=0.
- avail = (FETCH & imem_ready) | HOLD. cur_inst = imem_rdata in FETCH, hold_inst in HOLD.
- Advance (avail & wpcir): dinst<=cur_inst, dpc4<=pc+4, dflush<=flush, pc<=npc, state<=FETCH.
- FETCH, ready=1, wpcir=0: hold_inst<=imem_rdata, state<=HOLD. pc and IF/ID hold.
- HOLD, wpcir=0: everything holds.
- Bubble (!avail & wpcir): dinst<=0, dflush<=0, dpc4 holds.
  - If pcsource!=00: redir_pc<=npc, state<=DROP.
  - Otherwise stay.
- DROP: keep requesting the old pc. Discard the returned instruction when ready=1, then pc<=redir_pc, state<=FETCH.
  - wpcir=1 in DROP gives a bubble.
  - A redirect (pcsource!=00 with wpcir=1) in DROP overwrites redir_pc; last wins.
- Simultaneous ready and redirect in FETCH is a normal advance. The fetched instruction enters ID with dflush=flush and pc<=target.
- Zero-wait memory (ready tied 1): one instruction per cycle, no bubbles.
- Reset mid-fetch: the outstanding response is discarded and the first request after reset is to RESET_PC.
- Latency: instruction to ID one edge after ready when wpcir=1.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds output if_bubble_cnt[31:0]. Resets to 0, increments on every bubble insertion, wraps at 2^32.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JR=2'b10, PCSRC_J=2'b11.
  - INST_NOP=32'h0.
  - Fetch state encoding FETCH/HOLD/DROP.
- One combinational sub-module pipeif_npc (pc, bpc, rpc, jpc, pcsource -> npc). The FSM and registers stay in pipeif_fetch.

Test Plan:
1. Reset, ready=1, wpcir=1, pcsource=00, rdata=addr+0x100 -> addresses 0,4,8,C on consecutive cycles; dinst=0x100,0x104,… one cycle later; dpc4=4,8,C.
2. Stall: wpcir=0 for 3 cycles while ready=1 at pc=8 -> state HOLD, imem_req=0, pc=8, dinst frozen. Releasing wpcir -> held instruction enters ID, pc=C.
3. Branch: pcsource=01, bpc=0x40, flush=1 with ready=1 -> dflush=1 next cycle, imem_addr=0x40.
4. Slow memory: ready low 2 cycles, wpcir=1 -> two dinst=0 bubbles with dpc4 unchanged, then instruction delivered.
5. Redirect during pending fetch: ready=0, pcsource=11, jpc=0x80 -> DROP. Old address held until ready, response discarded, next request at 0x80.
6. Reset asserted while ready=0 in DROP -> next cycle pc=RESET_PC, dinst=0, state FETCH; if_bubble_cnt=0 when IF_PERF_CNT_EN is defined.
